// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two requesting ports, the shared data memory and the
// arbiter. The arbiter takes the slave view. The environment holding the core,
// the debug port and the memory takes the master view.
interface dmem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              c_req;
    logic              c_we;
    logic [ADDR_W-1:0] c_addr;
    logic [DATA_W-1:0] c_wdata;
    logic              c_gnt;
    logic              c_rvalid;
    logic [DATA_W-1:0] c_rdata;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;

    logic              core_stall;

    logic              m_en;
    logic              m_we;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata;
    logic [DATA_W-1:0] m_rdata;

    modport master (
        output c_req, c_we, c_addr, c_wdata,
        output d_req, d_we, d_addr, d_wdata,
        output m_rdata,
        input  c_gnt, c_rvalid, c_rdata,
        input  d_gnt, d_rvalid, d_rdata,
        input  core_stall,
        input  m_en, m_we, m_addr, m_wdata
    );

    modport slave (
        input  c_req, c_we, c_addr, c_wdata,
        input  d_req, d_we, d_addr, d_wdata,
        input  m_rdata,
        output c_gnt, c_rvalid, c_rdata,
        output d_gnt, d_rvalid, d_rdata,
        output core_stall,
        output m_en, m_we, m_addr, m_wdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter and sequencer that lets the core load/store port and the
// debug/loader port share a single-ported data memory with a fixed read latency.
// Only one transaction is in flight at a time. A read keeps the arbiter in
// RD_WAIT until the memory data is captured for the port that issued it.
module dmem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 1
) (
    input  logic           clk,
    input  logic           reset,
    dmem_arbiter_if.slave  bus
);

    typedef enum logic {
        IDLE    = 1'b0,
        RD_WAIT = 1'b1
    } state_t;

    localparam logic [2:0] LAT_LOAD = 3'(MEM_LAT);

    state_t      state;
    state_t      state_next;
    logic [2:0]  lat_cnt;
    logic [2:0]  lat_cnt_next;
    logic        owner;
    logic        owner_next;
    logic        last_gnt;
    logic        last_gnt_next;

    logic        grant_c;
    logic        grant_d;
    logic        grant_we;
    logic        capture;

    logic              c_rvalid_q;
    logic              d_rvalid_q;
    logic [DATA_W-1:0] c_rdata_q;
    logic [DATA_W-1:0] d_rdata_q;

    // owner and last_gnt use 1 for debug and 0 for core.
    // Arbitration happens only in IDLE. A read grant parks the FSM in RD_WAIT
    // until the memory data is due.
    always_comb begin
        state_next    = state;
        lat_cnt_next  = lat_cnt;
        owner_next    = owner;
        last_gnt_next = last_gnt;
        grant_c       = 1'b0;
        grant_d       = 1'b0;
        grant_we      = 1'b0;
        capture       = 1'b0;
        case (state)
            IDLE: begin
                if (bus.c_req && bus.d_req) begin
                    grant_c = last_gnt;
                    grant_d = ~last_gnt;
                end else begin
                    grant_c = bus.c_req;
                    grant_d = bus.d_req;
                end
                grant_we = grant_c ? bus.c_we : bus.d_we;
                if (grant_c || grant_d) begin
                    last_gnt_next = grant_d;
                    if (!grant_we) begin
                        state_next   = RD_WAIT;
                        lat_cnt_next = LAT_LOAD;
                        owner_next   = grant_d;
                    end
                end
            end
            RD_WAIT: begin
                lat_cnt_next = lat_cnt - 3'd1;
                if (lat_cnt == 3'd1) begin
                    capture    = 1'b1;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // FSM, latency counter, read owner and round-robin pointer registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            lat_cnt  <= 3'd0;
            owner    <= 1'b0;
            last_gnt <= 1'b1;
        end else begin
            state    <= state_next;
            lat_cnt  <= lat_cnt_next;
            owner    <= owner_next;
            last_gnt <= last_gnt_next;
        end
    end

    // Returned read data lands only in the owner's registers. The rvalid pulse
    // appears the cycle after the memory data is sampled.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            c_rvalid_q <= 1'b0;
            d_rvalid_q <= 1'b0;
            c_rdata_q  <= '0;
            d_rdata_q  <= '0;
        end else begin
            c_rvalid_q <= capture && !owner;
            d_rvalid_q <= capture && owner;
            if (capture && !owner) begin
                c_rdata_q <= bus.m_rdata;
            end
            if (capture && owner) begin
                d_rdata_q <= bus.m_rdata;
            end
        end
    end

    assign bus.c_gnt      = grant_c;
    assign bus.d_gnt      = grant_d;
    assign bus.core_stall = bus.c_req && !grant_c;

    assign bus.m_en    = grant_c || grant_d;
    assign bus.m_we    = (grant_c || grant_d) && grant_we;
    assign bus.m_addr  = grant_c ? bus.c_addr  : (grant_d ? bus.d_addr  : '0);
    assign bus.m_wdata = grant_c ? bus.c_wdata : (grant_d ? bus.d_wdata : '0);

    assign bus.c_rvalid = c_rvalid_q;
    assign bus.d_rvalid = d_rvalid_q;
    assign bus.c_rdata  = c_rdata_q;
    assign bus.d_rdata  = d_rdata_q;

endmodule
